// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : State, opcode and select encodings for the multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_BNE      = 4'd12;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_out_decode.sv
// ============================================================================
// Module   : mc_ctrl_out_decode
// Brief    : Combinational state-to-control decode; honours MC_CTRL_BNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    input  logic       rst_n_i,
    output logic       iord_o,
    output logic       alusrca_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [1:0] alu_op_o,
    output logic       irwrite_o,
    output logic       memwrite_o,
    output logic       regwrite_o,
    output logic       pcen_o
);

    logic [3:0] eff_state;

    // Reset masquerades as FETCH so selects settle and the FETCH strobes gate off.
    assign eff_state = rst_n_i ? state_i : S_FETCH;

    always_comb begin
        iord_o     = 1'b0;
        alusrca_o  = 1'b0;
        regdst_o   = 1'b0;
        memtoreg_o = 1'b0;
        alusrcb_o  = SRCB_REG;
        pcsrc_o    = PCSRC_ALU;
        alu_op_o   = ALU_OP_ADD;
        irwrite_o  = 1'b0;
        memwrite_o = 1'b0;
        regwrite_o = 1'b0;
        pcen_o     = 1'b0;
        case (eff_state)
            S_FETCH: begin
                alusrcb_o = SRCB_FOUR;
                irwrite_o = mem_ready_i & rst_n_i;
                pcen_o    = mem_ready_i & rst_n_i;
            end
            S_DECODE:   alusrcb_o = SRCB_IMM_SH2;
            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = SRCB_IMM;
            end
            S_MEMREAD:  iord_o = 1'b1;
            S_MEMWB: begin
                memtoreg_o = 1'b1;
                regwrite_o = 1'b1;
            end
            S_MEMWRITE: begin
                iord_o     = 1'b1;
                memwrite_o = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_o = 1'b1;
                alu_op_o  = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                regdst_o   = 1'b1;
                regwrite_o = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o = 1'b1;
                alu_op_o  = ALU_OP_SUB;
                pcsrc_o   = PCSRC_ALUOUT;
                pcen_o    = zero_i;
            end
            S_ADDIEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = SRCB_IMM;
            end
            S_ADDIWB:   regwrite_o = 1'b1;
            S_JUMP: begin
                pcsrc_o = PCSRC_JUMP;
                pcen_o  = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                alusrca_o = 1'b1;
                alu_op_o  = ALU_OP_SUB;
                pcsrc_o   = PCSRC_ALUOUT;
                pcen_o    = ~zero_i;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multi-cycle MIPS control FSM; MC_CTRL_BNE_EN adds the BNE state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALU_Op,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        illegal_dec = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      illegal_dec = 1'b1;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    assign state      = state_q;
    assign illegal_op = illegal_dec & rst_n;

    mc_ctrl_out_decode u_out_decode (
        .state_i     (state_q),
        .zero_i      (Zero),
        .mem_ready_i (mem_ready),
        .rst_n_i     (rst_n),
        .iord_o      (IorD),
        .alusrca_o   (ALUSrcA),
        .regdst_o    (RegDst),
        .memtoreg_o  (MemtoReg),
        .alusrcb_o   (ALUSrcB),
        .pcsrc_o     (PCSrc),
        .alu_op_o    (ALU_Op),
        .irwrite_o   (IRWrite),
        .memwrite_o  (MemWrite),
        .regwrite_o  (RegWrite),
        .pcen_o      (PCEn)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Directed self-checking bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc, ALU_Op;
    logic       IRWrite, MemWrite, RegWrite, PCEn, illegal_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALU_Op     (ALU_Op),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCEn       (PCEn),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Op = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if ({IRWrite, PCEn, MemWrite, RegWrite, illegal_op} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000", {IRWrite, PCEn, MemWrite, RegWrite, illegal_op});
        end
        total++; if ({IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALU_Op} !== 10'b0000_01_00_00) begin
            bad++; $display("FAIL reset_selects: got %b want 0000010000", {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALU_Op});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] seq [0:4];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        Op = 6'b100011; mem_ready = 1'b1;
        #1;
        total++; if ({state, IRWrite, PCEn, ALUSrcB} !== {4'd0, 1'b1, 1'b1, 2'b01}) begin
            bad++; $display("FAIL lw_fetch: got st=%0d ir=%b pcen=%b srcb=%b want 0 1 1 01", state, IRWrite, PCEn, ALUSrcB);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (state !== seq[i]) begin bad++; $display("FAIL lw_seq%0d: got %0d want %0d", i, state, seq[i]); end
            if (i < 4) begin
                total++; if ({IRWrite, PCEn} !== 2'b00) begin bad++; $display("FAIL lw_irpc%0d: got %b want 00", i, {IRWrite, PCEn}); end
            end
            if (i == 1) begin
                total++; if ({ALUSrcA, ALUSrcB} !== 3'b1_10) begin bad++; $display("FAIL lw_memadr: got %b want 110", {ALUSrcA, ALUSrcB}); end
            end
            if (i == 2) begin
                total++; if (IorD !== 1'b1) begin bad++; $display("FAIL lw_iord: got %b want 1", IorD); end
            end
            if (i == 3) begin
                total++; if ({RegWrite, MemtoReg, RegDst} !== 3'b110) begin bad++; $display("FAIL lw_wb: got %b want 110", {RegWrite, MemtoReg, RegDst}); end
            end
        end
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0; Op = 6'b000010;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if ({state, IRWrite, PCEn} !== {4'd0, 2'b00}) begin
                bad++; $display("FAIL fetch_stall%0d: got st=%0d ir=%b pcen=%b want 0 0 0", i, state, IRWrite, PCEn);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        total++; if (state !== 4'd1) begin bad++; $display("FAIL fetch_release: got %0d want 1", state); end
        tick();
        total++; if ({state, PCEn, PCSrc} !== {4'd11, 1'b1, 2'b10}) begin
            bad++; $display("FAIL jump: got st=%0d pcen=%b pcsrc=%b want 11 1 10", state, PCEn, PCSrc);
        end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL jump_ret: got %0d want 0", state); end
    endtask

    task automatic test_sw_stall();
        Op = 6'b101011; mem_ready = 1'b1;
        tick(); tick();
        total++; if (state !== 4'd2) begin bad++; $display("FAIL sw_memadr: got %0d want 2", state); end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            total++; if ({state, MemWrite, IorD} !== {4'd5, 2'b11}) begin
                bad++; $display("FAIL sw_hold%0d: got st=%0d mw=%b iord=%b want 5 1 1", i, state, MemWrite, IorD);
            end
            tick();
        end
        total++; if ({state, MemWrite} !== {4'd0, 1'b0}) begin bad++; $display("FAIL sw_ret: got st=%0d mw=%b want 0 0", state, MemWrite); end
    endtask

    task automatic test_beq(input logic z);
        Op = 6'b000100; mem_ready = 1'b1; Zero = z;
        tick(); tick();
        total++; if ({state, PCEn, PCSrc, ALU_Op, ALUSrcA} !== {4'd8, z, 2'b01, 2'b01, 1'b1}) begin
            bad++; $display("FAIL beq_z%0d: got st=%0d pcen=%b pcsrc=%b aluop=%b want 8 %b 01 01", z, state, PCEn, PCSrc, ALU_Op, z);
        end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL beq_ret_z%0d: got %0d want 0", z, state); end
        Zero = 1'b0;
    endtask

    task automatic test_addi();
        Op = 6'b001000; mem_ready = 1'b1;
        tick();
        tick();
        total++; if ({state, ALUSrcA, ALUSrcB, ALU_Op} !== {4'd9, 1'b1, 2'b10, 2'b00}) begin
            bad++; $display("FAIL addiex: got st=%0d a=%b b=%b op=%b want 9 1 10 00", state, ALUSrcA, ALUSrcB, ALU_Op);
        end
        tick();
        total++; if ({state, RegWrite, RegDst, MemtoReg} !== {4'd10, 3'b100}) begin
            bad++; $display("FAIL addiwb: got st=%0d rw=%b rd=%b m2r=%b want 10 1 0 0", state, RegWrite, RegDst, MemtoReg);
        end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL addi_ret: got %0d want 0", state); end
    endtask

    task automatic test_illegal();
        Op = 6'b111111; mem_ready = 1'b1;
        #1;
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL illegal_pre: got %b want 0", illegal_op); end
        tick();
        total++; if ({state, illegal_op} !== {4'd1, 1'b1}) begin
            bad++; $display("FAIL illegal_pulse: got st=%0d ill=%b want 1 1", state, illegal_op);
        end
        total++; if ({IRWrite, MemWrite, RegWrite, PCEn} !== 4'b0) begin
            bad++; $display("FAIL illegal_strobes: got %b want 0000", {IRWrite, MemWrite, RegWrite, PCEn});
        end
        mem_ready = 1'b0;
        tick();
        total++; if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            bad++; $display("FAIL illegal_after: got st=%0d ill=%b want 0 0", state, illegal_op);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        Op = 6'b000000; mem_ready = 1'b1;
        tick(); tick();
        total++; if ({state, ALU_Op, ALUSrcA, ALUSrcB} !== {4'd6, 2'b10, 1'b1, 2'b00}) begin
            bad++; $display("FAIL execute: got st=%0d op=%b a=%b b=%b want 6 10 1 00", state, ALU_Op, ALUSrcA, ALUSrcB);
        end
        tick();
        total++; if ({state, RegWrite, RegDst} !== {4'd7, 2'b11}) begin
            bad++; $display("FAIL aluwb: got st=%0d rw=%b rd=%b want 7 1 1", state, RegWrite, RegDst);
        end
        rst_n = 1'b0;
        #1;
        total++; if ({RegWrite, RegDst, ALUSrcB} !== 4'b0001) begin
            bad++; $display("FAIL rst_in_aluwb: got rw=%b rd=%b b=%b want 0 0 01", RegWrite, RegDst, ALUSrcB);
        end
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_mid_state: got %0d want 0", state); end
        rst_n = 1'b1;
    endtask

    task automatic test_bne();
        Op = 6'b000101; mem_ready = 1'b1; Zero = 1'b0;
        tick();
`ifdef MC_CTRL_BNE_EN
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL bne_legal: got %b want 0", illegal_op); end
        tick();
        total++; if ({state, PCEn, PCSrc} !== {4'd12, 1'b1, 2'b01}) begin
            bad++; $display("FAIL bne_state: got st=%0d pcen=%b pcsrc=%b want 12 1 01", state, PCEn, PCSrc);
        end
`else
        total++; if ({state, illegal_op} !== {4'd1, 1'b1}) begin
            bad++; $display("FAIL bne_illegal: got st=%0d ill=%b want 1 1", state, illegal_op);
        end
`endif
        tick();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL bne_ret: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_stall();
        test_sw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_addi();
        test_illegal();
        test_reset_mid();
        test_bne();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
